// File: rtl/irq_pkg.sv
// Shared types, register offsets and helpers for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_CLAIM} irq_state_t;

  localparam int unsigned MAX_SRC = 6;

  localparam logic [4:0] IRQ_ENABLE   = 5'h00;
  localparam logic [4:0] IRQ_TRIG     = 5'h04;
  localparam logic [4:0] IRQ_PENDING  = 5'h08;
  localparam logic [4:0] IRQ_CLAIM    = 5'h0C;
  localparam logic [4:0] IRQ_COMPLETE = 5'h10;

  // Returns id+1 of the lowest set bit, 0 when none is set.
  function automatic logic [2:0] lowest_claim(input logic [MAX_SRC-1:0] v);
    lowest_claim = '0;
    for (int unsigned i = MAX_SRC; i > 0; i--) begin
      if (v[i-1]) lowest_claim = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_src_fsm.sv
// One interrupt source: input synchroniser, edge detect, PENDING/CLAIMED
// state machine and the repeat flag that remembers an edge seen while claimed.
module irq_src_fsm
  import irq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_src,
  input  logic       i_trig_mode,
  input  logic       i_claim_hit,
  input  logic       i_complete_hit,
  input  logic       i_trig_wr,
  output irq_state_t o_state
);

  logic       r_s1, r_s2, r_s3;
  logic       r_repeat, w_repeat_nxt;
  logic       w_edge, w_trig;
  irq_state_t r_state, w_state_nxt;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;
  assign w_trig = i_trig_mode ? w_edge : r_s2;

  // State and repeat flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  // Next state: bus claim/complete take priority over a trigger in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_repeat_nxt = r_repeat;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig) w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (i_claim_hit) begin
          w_state_nxt = S_CLAIM;
          if (i_trig_mode && w_edge) w_repeat_nxt = 1'b1;
        end
      end
      S_CLAIM: begin
        if (i_complete_hit) begin
          w_state_nxt  = r_repeat ? S_PEND : S_IDLE;
          w_repeat_nxt = 1'b0;
        end else if (i_trig_mode && w_edge) begin
          w_repeat_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_repeat_nxt = 1'b0;
      end
    endcase
    if (i_trig_wr) w_repeat_nxt = 1'b0;
  end

  assign o_state = r_state;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller driving CP0 HWInt[5:0].
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            sel,
  input  logic [4:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [5:0]      hwint
);

  logic [NSRC-1:0]    r_enable;
  logic [NSRC-1:0]    r_trig;
  logic [MAX_SRC-1:0] r_hwint;
  logic [MAX_SRC-1:0] w_pend;
  logic [MAX_SRC-1:0] w_en_full;
  logic [MAX_SRC-1:0] w_claimable;
  logic [4:0]         w_off;
  logic               w_wr;
  logic               w_wr_claim, w_wr_complete, w_wr_trig;
  logic [1:0]         w_unused_addr;

  assign w_off         = {addr[4:2], 2'b00};
  assign w_unused_addr = addr[1:0];
  assign w_wr          = sel & we;
  assign w_wr_claim    = w_wr && (w_off == IRQ_CLAIM);
  assign w_wr_complete = w_wr && (w_off == IRQ_COMPLETE);
  assign w_wr_trig     = w_wr && (w_off == IRQ_TRIG);

  // Per-source state machines; sources beyond NSRC never pend.
  for (genvar gi = 0; gi < MAX_SRC; gi++) begin : g_src
    if (gi < NSRC) begin : g_on
      irq_state_t w_state;
      irq_src_fsm u_fsm (
        .clk           (clk),
        .reset         (reset),
        .i_src         (src_irq[gi]),
        .i_trig_mode   (r_trig[gi]),
        .i_claim_hit   (w_wr_claim && (wdata == 32'(gi + 1))),
        .i_complete_hit(w_wr_complete && (wdata == 32'(gi + 1))),
        .i_trig_wr     (w_wr_trig),
        .o_state       (w_state)
      );
      assign w_pend[gi] = (w_state == S_PEND);
    end else begin : g_off
      assign w_pend[gi] = 1'b0;
    end
  end

  // Zero-extend the enable mask to the full HWInt width.
  always_comb begin
    w_en_full           = '0;
    w_en_full[NSRC-1:0] = r_enable;
  end

  assign w_claimable = w_pend & w_en_full;

  // ENABLE/TRIG registers and registered interrupt outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable <= '0;
      r_trig   <= '0;
      r_hwint  <= '0;
    end else begin
      if (w_wr && (w_off == IRQ_ENABLE)) r_enable <= wdata[NSRC-1:0];
      if (w_wr_trig)                     r_trig   <= wdata[NSRC-1:0];
      r_hwint <= w_claimable;
    end
  end

  assign hwint = r_hwint;

  // Combinational read mux; unselected or unmapped reads return zero.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (w_off)
        IRQ_ENABLE:  rdata = {{(32-MAX_SRC){1'b0}}, w_en_full};
        IRQ_TRIG:    rdata[NSRC-1:0] = r_trig;
        IRQ_PENDING: rdata = {{(32-MAX_SRC){1'b0}}, w_pend};
        IRQ_CLAIM:   rdata = {29'b0, lowest_claim(w_claimable)};
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  src_irq = '0;
  logic        sel = 1'b0;
  logic [4:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [5:0]  hwint;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.NSRC(6)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .sel(sel), .addr(addr),
    .we(we), .wdata(wdata), .rdata(rdata), .hwint(hwint)
  );

  always #10 clk = ~clk;

  // Behavioural model: source status 0=idle, 1=pending, 2=claimed.
  int       m_st[6];
  bit       m_rep[6];
  bit [2:0] m_hist[6];   // [0]=newest sample of the raw line
  bit [5:0] m_en, m_trig, m_hw;

  function automatic bit [31:0] m_read(input bit s, input bit [4:0] a);
    bit [5:0] p;
    bit [31:0] r;
    r = 0;
    for (int i = 0; i < 6; i++) p[i] = (m_st[i] == 1);
    if (!s) return 0;
    case (a >> 2)
      0: r = m_en;
      1: r = m_trig;
      2: r = p;
      3: for (int i = 5; i >= 0; i--) if (p[i] && m_en[i]) r = i + 1;
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic tick();
    int       ns[6];
    bit       nr[6];
    bit [2:0] nh[6];
    bit [5:0] nen, ntrig, nhw;
    bit       wr, seen, edg, lvl;
    int       off;
    wr  = sel && we;
    off = addr >> 2;
    nen = m_en; ntrig = m_trig;
    for (int i = 0; i < 6; i++) begin
      // The model sees the line two samples late (synchroniser delay).
      lvl = m_hist[i][1];
      edg = m_hist[i][1] && !m_hist[i][2];
      seen = m_trig[i] ? edg : lvl;
      nhw[i] = (m_st[i] == 1) && m_en[i];
      ns[i] = m_st[i]; nr[i] = m_rep[i];
      if (m_st[i] == 0 && seen) ns[i] = 1;
      if (m_st[i] == 1 && wr && off == 3 && wdata == i + 1) begin
        ns[i] = 2;
        if (m_trig[i] && edg) nr[i] = 1;
      end
      if (m_st[i] == 2) begin
        if (wr && off == 4 && wdata == i + 1) begin
          ns[i] = m_rep[i] ? 1 : 0;
          nr[i] = 0;
        end else if (m_trig[i] && edg) nr[i] = 1;
      end
      if (wr && off == 1) nr[i] = 0;
      nh[i] = {m_hist[i][1:0], src_irq[i]};
    end
    if (wr && off == 0) nen = wdata[5:0];
    if (wr && off == 1) ntrig = wdata[5:0];
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 6; i++) begin m_st[i] = 0; m_rep[i] = 0; m_hist[i] = 0; end
      m_en = 0; m_trig = 0; m_hw = 0;
    end else begin
      for (int i = 0; i < 6; i++) begin m_st[i] = ns[i]; m_rep[i] = nr[i]; m_hist[i] = nh[i]; end
      m_en = nen; m_trig = ntrig; m_hw = nhw;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input bit [4:0] a, input bit [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    tick();
    sel = 0; we = 0; wdata = 0;
  endtask

  task automatic rd(input bit [4:0] a, output bit [31:0] d);
    sel = 1; we = 0; addr = a;
    #1;
    d = rdata;
    sel = 0;
  endtask

  task automatic do_reset();
    src_irq = 0; sel = 0; we = 0;
    reset = 1; ticks(2); reset = 0;
  endtask

  task automatic test_reset();
    bit [31:0] d;
    do_reset();
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL reset_hwint got=%b exp=000000", hwint); end
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_nosel_rdata got=%h exp=0", rdata); end
    rd(5'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_enable got=%h exp=0", d); end
    rd(5'h04, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_trig got=%h exp=0", d); end
  endtask

  task automatic test_basic_edge();
    bit [31:0] d;
    do_reset();
    wr(5'h00, 32'h1); wr(5'h04, 32'h1);
    src_irq = 6'b000001;
    ticks(3);
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL edge_early got=%b exp=000000", hwint); end
    src_irq = 0;
    tick();
    checks++; if (hwint !== 6'b000001) begin errors++; $display("FAIL edge_hwint got=%b exp=000001", hwint); end
    rd(5'h08, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_pending got=%h exp=1", d); end
    rd(5'h0C, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_claim got=%h exp=1", d); end
  endtask

  task automatic test_priority_claim();
    bit [31:0] d;
    do_reset();
    wr(5'h00, 32'h3F); wr(5'h04, 32'h3F);
    src_irq = 6'b010100; tick(); src_irq = 0; ticks(3);
    rd(5'h0C, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL prio_claim got=%h exp=3", d); end
    checks++; if (hwint !== 6'b010100) begin errors++; $display("FAIL prio_hwint got=%b exp=010100", hwint); end
    wr(5'h0C, 32'h3);
    rd(5'h0C, d); checks++; if (d !== 32'h5) begin errors++; $display("FAIL prio_claim_after got=%h exp=5", d); end
    tick();
    checks++; if (hwint !== 6'b010000) begin errors++; $display("FAIL prio_hwint_after got=%b exp=010000", hwint); end
    wr(5'h10, 32'h3);
    rd(5'h08, d); checks++; if (d !== 32'h10) begin errors++; $display("FAIL prio_complete_pending got=%h exp=10", d); end
  endtask

  task automatic test_level();
    bit [31:0] d;
    do_reset();
    wr(5'h00, 32'h2);
    src_irq = 6'b000010; ticks(4);
    checks++; if (hwint !== 6'b000010) begin errors++; $display("FAIL level_hwint got=%b exp=000010", hwint); end
    wr(5'h0C, 32'h2); tick();
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL level_claimed got=%b exp=000000", hwint); end
    wr(5'h10, 32'h2); tick();
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL level_repend_early got=%b exp=000000", hwint); end
    tick();
    checks++; if (hwint !== 6'b000010) begin errors++; $display("FAIL level_repend got=%b exp=000010", hwint); end
    src_irq = 0;
    wr(5'h0C, 32'h2); wr(5'h10, 32'h2); ticks(3);
    rd(5'h08, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL level_idle_pending got=%h exp=0", d); end
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL level_idle_hwint got=%b exp=000000", hwint); end
  endtask

  task automatic test_repeat();
    bit [31:0] d;
    do_reset();
    wr(5'h00, 32'h1); wr(5'h04, 32'h1);
    src_irq = 1; tick(); src_irq = 0; ticks(3);
    wr(5'h0C, 32'h1);
    src_irq = 1; tick(); src_irq = 0; ticks(3);
    wr(5'h10, 32'h1);
    rd(5'h08, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL repeat_pending got=%h exp=1", d); end
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL repeat_hwint_early got=%b exp=000000", hwint); end
    tick();
    checks++; if (hwint !== 6'b000001) begin errors++; $display("FAIL repeat_hwint got=%b exp=000001", hwint); end
  endtask

  task automatic test_masking();
    bit [31:0] d;
    do_reset();
    wr(5'h04, 32'h08);
    src_irq = 6'b001000; tick(); src_irq = 0; ticks(4);
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL mask_hwint got=%b exp=000000", hwint); end
    rd(5'h08, d); checks++; if (d !== 32'h08) begin errors++; $display("FAIL mask_pending got=%h exp=8", d); end
    rd(5'h0C, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL mask_claim got=%h exp=0", d); end
    wr(5'h00, 32'h08);
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL mask_enable_early got=%b exp=000000", hwint); end
    tick();
    checks++; if (hwint !== 6'b001000) begin errors++; $display("FAIL mask_enable got=%b exp=001000", hwint); end
  endtask

  task automatic test_illegal_and_reset();
    bit [31:0] d;
    do_reset();
    wr(5'h00, 32'h3F); wr(5'h04, 32'h3F);
    src_irq = 1; tick(); src_irq = 0; ticks(3);
    wr(5'h0C, 32'h0); wr(5'h0C, 32'h7); wr(5'h10, 32'h1); wr(5'h10, 32'h3);
    rd(5'h08, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL illegal_pending got=%h exp=1", d); end
    rd(5'h0C, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL illegal_claim got=%h exp=1", d); end
    rd(5'h14, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", d); end
    wr(5'h0C, 32'h1);
    rd(5'h08, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL claimed_pending got=%h exp=0", d); end
    sel = 1; we = 1; addr = 5'h10; wdata = 1; reset = 1;
    tick();
    reset = 0; sel = 0; we = 0; wdata = 0;
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL midreset_hwint got=%b exp=000000", hwint); end
    rd(5'h00, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_enable got=%h exp=0", d); end
    rd(5'h04, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_trig got=%h exp=0", d); end
    wr(5'h00, 32'h1); wr(5'h10, 32'h1); tick();
    rd(5'h08, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_state got=%h exp=0", d); end
    checks++; if (hwint !== 6'b0) begin errors++; $display("FAIL midreset_idle_hwint got=%b exp=000000", hwint); end
  endtask

  task automatic test_random();
    bit [31:0] exp_rd;
    int unsigned r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      src_irq = 6'($urandom);
      r = $urandom_range(0, 99);
      reset = (r == 0);
      sel = (r < 60); we = (r >= 30 && r < 60);
      addr = 5'($urandom);
      if (we && (addr >> 2) >= 3) wdata = $urandom_range(0, 7);
      else wdata = $urandom;
      #1;
      exp_rd = m_read(sel, addr);
      checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata cyc=%0d addr=%h got=%h exp=%h", n, addr, rdata, exp_rd); end
      checks++; if (hwint !== m_hw) begin errors++; $display("FAIL rand_hwint cyc=%0d got=%b exp=%b", n, hwint, m_hw); end
      tick();
    end
    reset = 0; sel = 0; we = 0; src_irq = 0;
  endtask

  initial begin
    test_reset();
    test_basic_edge();
    test_priority_claim();
    test_level();
    test_repeat();
    test_masking();
    test_illegal_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
